// File: rtl/rot_arb_pkg.sv
// Shared types and constants for the two-requester rotator arbiter.
package rot_arb_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = $clog2(DATA_W);
  localparam int N_REQ  = 2;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, ROT, DONE} rot_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic              lr;
  } rot_req_t;

endpackage

// File: rtl/rot_core.sv
// Combinational log-stage rotator; left rotation reuses the right-rotate
// chain by bit-reversing the word before and after it.
module rot_core #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] word,
  input  logic [AMT_W-1:0]  amt,
  input  logic              lr,
  output logic [DATA_W-1:0] rotated
);

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    for (int i = 0; i < DATA_W; i++) bit_rev[i] = v[DATA_W-1-i];
  endfunction

  logic [DATA_W-1:0] chain;

  always_comb begin
    chain = lr ? bit_rev(word) : word;
    // Stage k rotates right by 2^k when amt[k] is set.
    for (int k = 0; k < AMT_W; k++) begin
      if (amt[k]) chain = (chain >> (1 << k)) | (chain << (DATA_W - (1 << k)));
    end
  end

  assign rotated = lr ? bit_rev(chain) : chain;

endmodule

// File: rtl/rot_arbiter.sv
// Round-robin arbiter sharing one rotator between two valid/ready requesters.
// Optional per-requester grant counters are enabled by defining ROT_ARB_STATS_EN.
module rot_arbiter #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = $clog2(DATA_W)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [rot_arb_pkg::N_REQ-1:0]        req_valid,
  output logic [rot_arb_pkg::N_REQ-1:0]        req_ready,
  input  logic [rot_arb_pkg::N_REQ*DATA_W-1:0] req_data,
  input  logic [rot_arb_pkg::N_REQ*AMT_W-1:0]  req_amt,
  input  logic [rot_arb_pkg::N_REQ-1:0]        req_lr,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [DATA_W-1:0]                   rsp_data,
`ifdef ROT_ARB_STATS_EN
  output logic [rot_arb_pkg::N_REQ*rot_arb_pkg::CNT_W-1:0] grant_cnt,
`endif
  output logic                                rsp_id
);

  import rot_arb_pkg::*;

  rot_state_t        state;
  logic              last_grant;
  logic              grant;
  logic              fire;
  logic [DATA_W-1:0] op_data;
  logic [AMT_W-1:0]  op_amt;
  logic              op_lr;
  logic              op_id;
  logic [DATA_W-1:0] core_out;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) grant = ~last_grant;
    else if (req_valid[1])  grant = 1'b1;
  end

  // Only the granted requester sees ready, and only while idle and out of reset.
  assign req_ready = (!reset && state == IDLE) ? (req_valid & (grant ? 2'b10 : 2'b01)) : 2'b00;
  assign fire      = |req_ready;

  rot_core #(.DATA_W(DATA_W), .AMT_W(AMT_W)) u_core (
    .word    (op_data),
    .amt     (op_amt),
    .lr      (op_lr),
    .rotated (core_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      // NOTE: operand registers are reset as well so the datapath never carries X after an abort.
      op_data    <= '0;
      op_amt     <= '0;
      op_lr      <= 1'b0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            op_data    <= grant ? req_data[DATA_W +: DATA_W] : req_data[0 +: DATA_W];
            op_amt     <= grant ? req_amt[AMT_W +: AMT_W] : req_amt[0 +: AMT_W];
            op_lr      <= req_lr[grant];
            op_id      <= grant;
            last_grant <= grant;
            state      <= ROT;
          end
        end
        ROT: begin
          rsp_data  <= core_out;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROT_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [N_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else if (fire && cnt[grant] != {CNT_W{1'b1}}) begin
      cnt[grant] <= cnt[grant] + 1'b1;
    end
  end

  assign grant_cnt = {cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_rot_arbiter.sv
// Self-checking bench for rot_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_rot_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [15:0] req_data = '0;
  logic [5:0]  req_amt = '0;
  logic [1:0]  req_lr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        rsp_id;
`ifdef ROT_ARB_STATS_EN
  logic [31:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one transaction in flight, visible two edges after acceptance.
  bit         in_flight = 1'b0;
  int         m_last = 1;
  int         avail_at = 0;
  int         cyc = 0;
  logic [7:0] m_data = '0;
  int         m_id = 0;
  int         m_cnt [2] = '{0, 0};
  int         obs_ids [$];

  rot_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_lr    (req_lr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
`ifdef ROT_ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rot_ref(input logic [7:0] w, input int amt, input bit left);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[i] = left ? w[(i - amt + 8) % 8] : w[(i + amt) % 8];
    return o;
  endfunction

  task automatic set_req(input int r, input logic [7:0] d, input int a, input bit l);
    req_data[r*8 +: 8] = d;
    req_amt[r*3 +: 3]  = a[2:0];
    req_lr[r]          = l;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    logic [1:0] exp_ready;
    logic       exp_rv;
    int         w;
    @(negedge clk);
    exp_ready = 2'b00;
    w = 0;
    if (!reset && !in_flight && req_valid != 2'b00) begin
      w = (req_valid == 2'b11) ? 1 - m_last : (req_valid[1] ? 1 : 0);
      exp_ready = 2'b01 << w;
    end
    exp_rv = !reset && in_flight && (cyc >= avail_at);
    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) begin
      check("rsp_data", rsp_data, m_data);
      check("rsp_id", rsp_id, m_id);
    end
    if (rsp_valid && rsp_ready) obs_ids.push_back(rsp_id);
    @(posedge clk);
    if (reset) begin
      in_flight = 1'b0;
      m_last = 1;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
    end else if (exp_rv && rsp_ready) begin
      in_flight = 1'b0;
    end else if (exp_ready != 2'b00) begin
      m_data    = rot_ref(req_data[w*8 +: 8], int'(req_amt[w*3 +: 3]), req_lr[w]);
      m_id      = w;
      m_last    = w;
      in_flight = 1'b1;
      avail_at  = cyc + 2;
      if (m_cnt[w] < 65535) m_cnt[w]++;
    end
    cyc++;
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (in_flight && n < 10) begin
      tick();
      n++;
    end
    rsp_ready = 1'b0;
    check({tag, "_drained"}, in_flight, 0);
  endtask

  task automatic run_one(input string tag, input int r, input logic [7:0] d, input int a,
                         input bit l, input logic [7:0] exp);
    set_req(r, d, a, l);
    req_valid = 2'b01 << r;
    rsp_ready = 1'b0;
    tick();
    req_valid = 2'b00;
    check({tag, "_rot"}, rsp_valid, 0);
    tick();
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_id"}, rsp_id, r);
    wait_rsp(tag);
  endtask

  initial begin
    logic [7:0] d;
    int         a;

    #1;
    check("rst_ready", req_ready, 0);
    check("rst_valid", rsp_valid, 0);
    repeat (2) tick();
    check("rst_data", rsp_data, 0);
    check("rst_id", rsp_id, 0);
    reset = 1'b0;

    run_one("rol3", 0, 8'hB1, 3, 1'b1, 8'h8D);
    run_one("ror3", 1, 8'hB1, 3, 1'b0, 8'h36);
    run_one("amt0", 1, 8'hB1, 0, 1'b1, 8'hB1);

    // Continuous contention with a free-running consumer.
    obs_ids.delete();
    set_req(0, 8'h5A, 1, 1'b1);
    set_req(1, 8'hC3, 2, 1'b0);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && obs_ids.size() < 4; i++) tick();
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    check("cont_count", obs_ids.size(), 4);
    for (int i = 0; i < obs_ids.size() && i < 4; i++) check("cont_id", obs_ids[i], i % 2);

    // Backpressure in DONE while the other requester waits.
    set_req(0, 8'hE7, 5, 1'b1);
    req_valid = 2'b01;
    tick();
    set_req(1, 8'h0F, 4, 1'b0);
    req_valid = 2'b10;
    tick();
    tick();
    repeat (5) begin
      tick();
      check("bp_ready", req_ready, 0);
      check("bp_hold", rsp_data, rot_ref(8'hE7, 5, 1'b1));
      check("bp_id", rsp_id, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_next_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    check("bp_next_acc", req_ready, 0);
    wait_rsp("bp_next");

    // Reset while the result is held: rsp_valid must drop without a clock.
    set_req(0, 8'h81, 1, 1'b1);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    check("abort_done_pre", rsp_valid, 1);
    reset = 1'b1;
    #1;
    check("abort_done_async", rsp_valid, 0);
    tick();
    reset = 1'b0;

    // Reset during the rotate cycle: no response afterwards.
    set_req(1, 8'h3C, 2, 1'b0);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    reset = 1'b1;
    #1;
    check("abort_rot", rsp_valid, 0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("abort_no_rsp", rsp_valid, 0);

    // First contention after reset goes to requester 0.
    set_req(0, 8'h12, 6, 1'b0);
    set_req(1, 8'h34, 7, 1'b1);
    req_valid = 2'b11;
    #1;
    check("post_rst_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    wait_rsp("post_rst");

    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      a = $urandom_range(0, 7);
      run_one("seq", i / 2, d, a, i[0], rot_ref(d, a, i[0]));
    end
`ifdef ROT_ARB_STATS_EN
    check("grant_cnt_3_2", grant_cnt, 32'h0002_0003);
`endif

    // Random traffic, including occasional resets.
    for (int i = 0; i < 400; i++) begin
      req_data  = 16'($urandom);
      req_amt   = 6'($urandom);
      req_lr    = 2'($urandom);
      req_valid = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    req_valid = 2'b00;
    wait_rsp("final");
`ifdef ROT_ARB_STATS_EN
    check("grant_cnt_final", grant_cnt, {m_cnt[1][15:0], m_cnt[0][15:0]});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
